spi_mem_responder: RTL and testbench
====================================

Name: spi_mem_responder

Overview:
- SPI mode-0 responder: the device end of the external memory bus (sclk/cs/mosi/miso) that the memory-bus initiator drives.
- Emulates a byte-addressed serial RAM using READ 0x03 and WRITE 0x02 commands with a 24-bit MSB-first address, backed by an internal byte array.
- Used on chip as a scratch RAM on the cs2 line, and as a synthesizable bus-functional model for CPU load/store and fetch tests.

Parameters:
- MEM_DEPTH, 256, number of bytes in the backing array; must be a power of two.
- ADDR_BITS, 24, address bits shifted in after the command byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sclk  in  1  SPI clock from initiator, asynchronous to clk
- cs_n  in  1  chip select, active-low
- mosi  in  1  serial data from initiator
- miso  out  1  serial data to initiator
- miso_oe  out  1  miso output enable; 1 only during data phase of a read
- busy  out  1  high while a transaction is in progress (synchronized cs_n low)
- wr_pulse  out  1  one-clk pulse per committed write byte
- wr_addr  out  ADDR_BITS  address of the committed byte, valid with wr_pulse
- wr_data  out  8  committed byte, valid with wr_pulse

Behaviour:
- Reset values: miso=0, miso_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, FSM=IDLE. Memory contents are not cleared by reset.
- Synchronization:
  - sclk, cs_n and mosi pass through 2-flop synchronizers.
  - A registered previous-sclk value produces rise and fall strobes.
  - Required sclk frequency <= clk/4; each sclk high and low phase >= 2 clk.
- Bit timing:
  - mosi is sampled on the rise strobe.
  - miso changes on the fall strobe, 3 clk after the pin edge.
  - Bits are MSB-first.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE.
- IDLE:
  - Synchronized cs_n falling -> CMD; bit counter=0; busy=1.
- CMD:
  - Shift in 8 bits.
  - On the 8th rise: 0x03 -> ADDR (read); 0x02 -> ADDR (write); any other value -> IGNORE.
- ADDR:
  - Shift in ADDR_BITS bits.
  - On the last rise: latch the address.
  - Read: load the shift register with mem[addr mod MEM_DEPTH] and go to RD_DATA.
  - Write: go to WR_DATA.
- RD_DATA:
  - On the first fall strobe after entry, miso_oe=1 and miso=bit7. Each subsequent fall shifts out the next bit.
  - After 8 falls the byte is done. The address increments, the next byte loads, and the next fall drives its bit7.
  - Continuous until cs_n rises.
- WR_DATA:
  - Shift 8 bits in on rises.
  - On the 8th rise: write mem[addr mod MEM_DEPTH], pulse wr_pulse for 1 clk with wr_addr/wr_data, then increment the address.
- Address arithmetic:
  - The internal address increments modulo 2^ADDR_BITS.
  - The array index is addr[log2(MEM_DEPTH)-1:0], so the array wraps at MEM_DEPTH.
  - wr_addr reports the full ADDR_BITS value.
- IGNORE:
  - miso_oe=0; all bits are discarded until cs_n rises.
- cs_n rising (synchronized), from any state:
  - Next clk: IDLE, busy=0, miso_oe=0, miso=0.
  - A partially received write byte is discarded with no memory update and no wr_pulse.
  - A partial command or address aborts silently.
- Transaction restart: a cs_n rise followed by a fall starts a new transaction from CMD. No state is retained except memory.
- rst mid-transaction: immediate IDLE with all outputs at reset values. The transaction resumes only after cs_n goes high and then low again; while rst is deasserted and cs_n is still low, the FSM waits in IDLE.
- sclk edges while cs_n is high are ignored.
- Simultaneous cs_n rise and sclk rise in the same clk: the cs_n rise wins and the bit is not sampled.

Optional Feature:
- Macro: SPI_MEM_RESPONDER_FAST_READ_EN.
- Defined:
  - Command 0x0B (FAST READ) is accepted. After the address, exactly 8 dummy sclk cycles are counted with miso_oe=0.
  - The behaviour is then identical to RD_DATA, with the first bit driven on the fall after the 8th dummy rise.
- Undefined: 0x0B goes to IGNORE like any unknown command.

Test Plan:
- Write 0x02, addr 0x000010, data 0xA5,0x3C, cs_n high -> wr_pulse twice: (0x000010,0xA5) then (0x000011,0x3C); mem[0x10]=0xA5, mem[0x11]=0x3C.
- Read 0x03, addr 0x000010, 16 data clocks -> miso shows 0xA5 then 0x3C; miso_oe=1 only in the data phase; busy drops 2-3 clk after cs_n rises.
- Wrap: write 0xFF to addr 0x0000FF, then read 2 bytes from 0x0000FF -> 0xFF then mem[0x00]; wr_addr=0x0000FF.
- Abort: write cmd, addr 0x20, 5 data bits, cs_n high -> no wr_pulse; mem[0x20] unchanged; next read of 0x20 returns the old value.
- Unknown cmd 0x9F plus 32 clocks -> miso_oe stays 0; no writes. Then rst pulsed mid-read -> miso_oe=0, busy=0 at the next clk.
- FAST_READ_EN: 0x0B, addr 0x10, 8 dummy clocks, 8 data clocks -> 0xA5. Without the macro -> miso_oe stays 0.

Source files
------------

// File: rtl/spi_mem_responder_if.sv
// spi_mem_responder_if: external SPI memory bus plus the committed-write report.
// The master modport is the bus initiator. The slave modport is the memory responder.
interface spi_mem_responder_if #(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 sclk;
  logic                 cs_n;
  logic                 mosi;
  logic                 miso;
  logic                 miso_oe;
  logic                 busy;
  logic                 wr_pulse;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_oe, busy, wr_pulse, wr_addr, wr_data
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_oe, busy, wr_pulse, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 serial-RAM responder (READ 0x03 / WRITE 0x02, 24-bit address).
// The byte array is indexed by the low address bits, so it wraps at MEM_DEPTH.
// Defining SPI_MEM_RESPONDER_FAST_READ_EN adds FAST READ 0x0B with 8 dummy clocks after the address.
module spi_mem_responder #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_BITS = 24
) (
  input  logic           i_clk,
  input  logic           i_rst,
  spi_mem_responder_if.slave io_bus
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = $clog2(ADDR_BITS) + 1;
  localparam logic [7:0]  CmdWrite = 8'h02;
  localparam logic [7:0]  CmdRead  = 8'h03;
`ifdef SPI_MEM_RESPONDER_FAST_READ_EN
  localparam logic [7:0]  CmdFastRead = 8'h0B;
`endif

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StRdData, StWrData, StIgnore, StDummy
  } state_e;

  logic r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic r_cs_s1, r_cs_s2, r_cs_prev;
  logic r_mosi_s1, r_mosi_s2;
  logic w_rise, w_fall, w_cs_fall, w_cs_rise;

  state_e r_state, w_state_next;

  logic [CntW-1:0]      r_bit_cnt;
  logic [7:0]           r_shift_in;
  logic [ADDR_BITS-1:0] r_addr_sh;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_is_read;
  logic                 r_is_fast;
  logic [7:0]           r_rd_shift;
  logic                 r_miso, r_miso_oe, r_busy, r_wr_pulse;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [7:0]           r_wr_data;
  logic [7:0]           r_mem [MEM_DEPTH];

  logic [7:0]           w_in_byte;
  logic [ADDR_BITS-1:0] w_addr_full, w_addr_inc;
  logic                 w_last8;
  logic                 w_cmd_read, w_cmd_write, w_cmd_fast;
  logic                 w_rise_ok, w_fall_ok;
  logic                 w_start, w_shift_en, w_cmd_done, w_addr_done, w_wr_commit, w_rd_step;

  // Bring the SPI pins into the clk domain and keep last values for edge strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      // cs_n path resets "low" so a select still held after reset never looks like a new fall.
      r_cs_s1     <= 1'b0;
      r_cs_s2     <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_mosi_s1   <= 1'b0;
      r_mosi_s2   <= 1'b0;
    end else begin
      r_sclk_s1   <= io_bus.sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_cs_s1     <= io_bus.cs_n;
      r_cs_s2     <= r_cs_s1;
      r_cs_prev   <= r_cs_s2;
      r_mosi_s1   <= io_bus.mosi;
      r_mosi_s2   <= r_mosi_s1;
    end
  end

  assign w_rise    = r_sclk_s2 & ~r_sclk_prev;
  assign w_fall    = ~r_sclk_s2 & r_sclk_prev;
  assign w_cs_fall = r_cs_prev & ~r_cs_s2;
  assign w_cs_rise = ~r_cs_prev & r_cs_s2;

  assign w_in_byte   = {r_shift_in[6:0], r_mosi_s2};
  assign w_addr_full = {r_addr_sh[ADDR_BITS-2:0], r_mosi_s2};
  assign w_addr_inc  = r_addr + ADDR_BITS'(1);
  assign w_last8     = (r_bit_cnt == CntW'(7));

  assign w_cmd_read  = (w_in_byte == CmdRead);
  assign w_cmd_write = (w_in_byte == CmdWrite);
`ifdef SPI_MEM_RESPONDER_FAST_READ_EN
  assign w_cmd_fast  = (w_in_byte == CmdFastRead);
`else
  assign w_cmd_fast  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; a deselect returns to idle from anywhere.
  always_comb begin
    w_state_next = r_state;
    if (w_cs_rise) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: if (w_start) w_state_next = StCmd;
        StCmd: begin
          if (w_cmd_done) begin
            if (w_cmd_read || w_cmd_write || w_cmd_fast) w_state_next = StAddr;
            else                                         w_state_next = StIgnore;
          end
        end
        StAddr: begin
          if (w_addr_done) begin
            if (!r_is_read)     w_state_next = StWrData;
            else if (r_is_fast) w_state_next = StDummy;
            else                w_state_next = StRdData;
          end
        end
        StDummy: if (w_shift_en && w_last8) w_state_next = StRdData;
        default: ;
      endcase
    end
  end

  // FSM outputs: per-state datapath strobes. A cs_n rise masks a coincident sclk edge.
  always_comb begin
    w_rise_ok   = w_rise & ~w_cs_rise;
    w_fall_ok   = w_fall & ~w_cs_rise;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_cmd_done  = 1'b0;
    w_addr_done = 1'b0;
    w_wr_commit = 1'b0;
    w_rd_step   = 1'b0;
    case (r_state)
      StIdle: w_start = w_cs_fall;
      StCmd: begin
        w_shift_en = w_rise_ok;
        w_cmd_done = w_rise_ok & w_last8;
      end
      StAddr: begin
        w_shift_en  = w_rise_ok;
        w_addr_done = w_rise_ok & (r_bit_cnt == CntW'(ADDR_BITS - 1));
      end
      StDummy: w_shift_en = w_rise_ok;
      StWrData: begin
        w_shift_en  = w_rise_ok;
        w_wr_commit = w_rise_ok & w_last8;
      end
      StRdData: w_rd_step = w_fall_ok;
      default: ;
    endcase
  end

  // Datapath: bit counter, shifters, address, read serializer and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt  <= '0;
      r_shift_in <= '0;
      r_addr_sh  <= '0;
      r_addr     <= '0;
      r_is_read  <= 1'b0;
      r_is_fast  <= 1'b0;
      r_rd_shift <= '0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_pulse <= 1'b0;

      if (w_state_next != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_wr_commit || (w_rd_step && w_last8)) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en || w_rd_step) begin
        r_bit_cnt <= r_bit_cnt + CntW'(1);
      end

      if (w_shift_en) begin
        r_shift_in <= w_in_byte;
        r_addr_sh  <= w_addr_full;
      end

      if (w_cmd_done) begin
        r_is_read <= w_cmd_read | w_cmd_fast;
        r_is_fast <= w_cmd_fast;
      end

      if (w_addr_done) begin
        r_addr     <= w_addr_full;
        r_rd_shift <= r_mem[w_addr_full[IdxW-1:0]];
      end else if (w_wr_commit) begin
        r_wr_pulse <= 1'b1;
        r_wr_addr  <= r_addr;
        r_wr_data  <= w_in_byte;
        r_addr     <= w_addr_inc;
      end else if (w_rd_step) begin
        r_miso    <= r_rd_shift[7];
        r_miso_oe <= 1'b1;
        // Eighth fall: the next byte is preloaded so the following fall drives its bit 7.
        if (w_last8) begin
          r_addr     <= w_addr_inc;
          r_rd_shift <= r_mem[w_addr_inc[IdxW-1:0]];
        end else begin
          r_rd_shift <= {r_rd_shift[6:0], 1'b0};
        end
      end

      if (w_start) r_busy <= 1'b1;

      if (w_cs_rise) begin
        r_busy    <= 1'b0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end
    end
  end

  // Backing store; deliberately untouched by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_commit) begin
      r_mem[r_addr[IdxW-1:0]] <= w_in_byte;
    end
  end

  assign io_bus.miso     = r_miso;
  assign io_bus.miso_oe  = r_miso_oe;
  assign io_bus.busy     = r_busy;
  assign io_bus.wr_pulse = r_wr_pulse;
  assign io_bus.wr_addr  = r_wr_addr;
  assign io_bus.wr_data  = r_wr_data;

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: randomized SPI transactions against a byte-array memory model,
// with scoreboard queues drained by independent write and read monitors.
module tb_spi_mem_responder;

  localparam int unsigned MemDepth = 256;
  localparam int unsigned AddrBits = 24;
  localparam int          Half     = 5;  // clk cycles per sclk phase

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_mem_responder_if #(.ADDR_BITS(AddrBits)) bus ();

  spi_mem_responder #(
    .MEM_DEPTH(MemDepth),
    .ADDR_BITS(AddrBits)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  model_mem [MemDepth];
  wr_t         exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  wdata_q [$];
  logic        exp_oe   = 1'b0;
  logic        rd_phase = 1'b0;

  wr_t         e_wr;
  logic [7:0]  e_rd;
  logic [7:0]  rd_sh = 8'h00;
  int          rd_bits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: command kinds 0 = other, 1 = read, 2 = write, 3 = fast read.
  function automatic int model_kind(input logic [7:0] c);
    if (c == 8'h03) return 1;
    if (c == 8'h02) return 2;
`ifdef SPI_MEM_RESPONDER_FAST_READ_EN
    if (c == 8'h0B) return 3;
`endif
    return 0;
  endfunction

  // Write monitor: every committed byte must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (bus.wr_pulse === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        chk("wr_unexpected_pulse", 32'(bus.wr_pulse), 32'd0);
      end else begin
        e_wr = exp_wr_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e_wr.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e_wr.data));
      end
    end
  end

  // Bus monitor: miso_oe on every selected rise, and read bytes assembled from miso.
  always @(posedge bus.sclk) begin
    if (bus.cs_n === 1'b0) begin
      chk("miso_oe", 32'(bus.miso_oe), 32'(exp_oe));
      if (rd_phase) begin
        rd_sh = {rd_sh[6:0], bus.miso};
        rd_bits++;
        if (rd_bits == 8) begin
          rd_bits = 0;
          if (exp_rd_q.size() == 0) begin
            chk("rd_unexpected_byte", 32'(exp_rd_q.size() != 0), 32'd1);
          end else begin
            e_rd = exp_rd_q.pop_front();
            chk("rd_byte", 32'(rd_sh), 32'(e_rd));
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b);
    bus.mosi = b;
    clks(Half);
    bus.sclk = 1'b1;
    clks(Half);
    bus.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_xfer(b[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) bit_xfer(a[i]);
  endtask

  task automatic cs_start();
    exp_oe   = 1'b0;
    rd_phase = 1'b0;
    bus.cs_n = 1'b0;
    clks(Half);
    chk("busy_on_select", 32'(bus.busy), 32'd1);
  endtask

  task automatic cs_end();
    int n;
    n = 0;
    exp_oe   = 1'b0;
    rd_phase = 1'b0;
    clks(2);
    bus.cs_n = 1'b1;
    while (bus.busy !== 1'b0 && n < 8) begin
      clks(1);
      n++;
    end
    chk("busy_drop_2to3_clk", 32'(n >= 2 && n <= 3), 32'd1);
    chk("oe_after_deselect", 32'(bus.miso_oe), 32'd0);
    chk("miso_after_deselect", 32'(bus.miso), 32'd0);
    clks(Half);
  endtask

  // One transaction; data comes from wdata_q when filled, otherwise random.
  task automatic txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes,
                     input int extra_bits, input bit sim_end);
    int          kind;
    logic [23:0] a;
    logic [7:0]  d;
    kind = model_kind(cmd);
    a    = addr;
    cs_start();
    send_byte(cmd);
    if (kind == 0) begin
      for (int i = 0; i < 24 + 8 * nbytes + extra_bits; i++) bit_xfer(1'($urandom));
    end else begin
      send_addr(addr);
      if (kind == 3) for (int i = 0; i < 8; i++) bit_xfer(1'($urandom));
      if (kind == 1 || kind == 3) begin
        exp_oe   = 1'b1;
        rd_phase = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
          exp_rd_q.push_back(model_mem[a % MemDepth]);
          send_byte(8'($urandom));
          a = a + 24'd1;
        end
      end else begin
        for (int k = 0; k < nbytes; k++) begin
          d = (wdata_q.size() != 0) ? wdata_q.pop_front() : 8'($urandom);
          exp_wr_q.push_back(wr_t'{a, d});
          model_mem[a % MemDepth] = d;
          send_byte(d);
          a = a + 24'd1;
        end
        for (int i = 0; i < extra_bits; i++) bit_xfer(1'($urandom));
      end
    end
    if (sim_end) begin
      // Deselect and an sclk rise land on the same clk; the bit must not be taken.
      bus.mosi = 1'($urandom);
      clks(Half);
      bus.cs_n = 1'b1;
      bus.sclk = 1'b1;
      clks(Half);
      bus.sclk = 1'b0;
      clks(2);
      chk("busy_after_sim_deselect", 32'(bus.busy), 32'd0);
      exp_oe   = 1'b0;
      rd_phase = 1'b0;
      clks(Half);
    end else begin
      cs_end();
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0]  c;
    logic [23:0] a;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst      = 1'b1;
    clks(3);
    chk("rst_miso", 32'(bus.miso), 32'd0);
    chk("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_pulse", 32'(bus.wr_pulse), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    rst = 1'b0;
    clks(4);

    // Give every array byte a known value.
    txn(8'h02, 24'h000000, MemDepth, 0, 1'b0);

    wdata_q = '{8'hA5, 8'h3C};
    txn(8'h02, 24'h000010, 2, 0, 1'b0);
    txn(8'h03, 24'h000010, 2, 0, 1'b0);

    // Array wrap at MEM_DEPTH, and full-width address wrap.
    wdata_q = '{8'hFF};
    txn(8'h02, 24'h0000FF, 1, 0, 1'b0);
    txn(8'h03, 24'h0000FF, 2, 0, 1'b0);
    txn(8'h02, 24'hFFFFFF, 2, 0, 1'b0);
    txn(8'h03, 24'hFFFFFF, 2, 0, 1'b0);

    // Partial write byte is dropped, including when deselect coincides with the 8th rise.
    txn(8'h02, 24'h000020, 0, 5, 1'b0);
    txn(8'h03, 24'h000020, 1, 0, 1'b0);
    txn(8'h02, 24'h000030, 0, 7, 1'b1);
    txn(8'h03, 24'h000030, 1, 0, 1'b0);

    txn(8'h9F, 24'h000000, 1, 0, 1'b0);

    // sclk activity while deselected must not start anything.
    for (int i = 0; i < 8; i++) bit_xfer(1'b1);
    chk("busy_while_deselected", 32'(bus.busy), 32'd0);

    txn(8'h0B, 24'h000010, 1, 0, 1'b0);

    // Reset in the middle of a read, then the responder must idle until reselected.
    cs_start();
    send_byte(8'h03);
    send_addr(24'h000010);
    exp_oe   = 1'b1;
    rd_phase = 1'b1;
    exp_rd_q.push_back(model_mem[8'h10]);
    send_byte(8'h00);
    rd_phase = 1'b0;
    clks(1);
    rst = 1'b1;
    clks(1);
    chk("rst_mid_read_oe", 32'(bus.miso_oe), 32'd0);
    chk("rst_mid_read_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_read_miso", 32'(bus.miso), 32'd0);
    rst    = 1'b0;
    exp_oe = 1'b0;
    for (int i = 0; i < 16; i++) bit_xfer(1'($urandom));
    chk("idle_after_rst_busy", 32'(bus.busy), 32'd0);
    bus.cs_n = 1'b1;
    clks(2 * Half);
    txn(8'h03, 24'h000010, 1, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0:       c = 8'h03;
        1:       c = 8'h02;
        2:       c = 8'h0B;
        default: c = 8'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) a = 24'($urandom);
      else                           a = 24'hFFFFFF - 24'($urandom_range(0, 2));
      txn(c, a, $urandom_range(1, 3), (c == 8'h02) ? $urandom_range(0, 7) : 0, 1'b0);
    end

    clks(10);
    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
